// File: rtl/prv32_alu_issue.sv
// prv32 ID/EX issue stage: decodes RV32I/M into ALU controls and registers
// them toward EX, holding MUL/DIV/REM for MD_LAT extra cycles.
//
// state  | meaning
// EMPTY  | no op held, ready to capture
// FULL   | op held, out_valid high, waiting for EX
// MDWAIT | mul/div op held while the ALU path settles, out_valid low
module prv32_alu_issue #(
    parameter int MD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_shamt,
    output logic [3:0]  out_alufn,
    output logic [4:0]  out_rd,
    output logic        out_wb_en,
    output logic        out_is_branch,
    output logic [2:0]  out_funct3,
    output logic        out_illegal
);

    localparam logic [3:0] FN_ADD = 4'b0000, FN_SUB = 4'b0001, FN_REM = 4'b0010,
                           FN_PASSB = 4'b0011, FN_OR = 4'b0100, FN_AND = 4'b0101,
                           FN_XOR = 4'b0111, FN_SLL = 4'b1000, FN_SRL = 4'b1001,
                           FN_SRA = 4'b1010, FN_MUL = 4'b1011, FN_SLT = 4'b1101,
                           FN_DIV = 4'b1110, FN_SLTU = 4'b1111;

    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011,
                           OPC_LOAD = 7'b0000011, OPC_JALR = 7'b1100111,
                           OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011,
                           OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                           OPC_JAL = 7'b1101111;

    localparam logic [3:0] MD_LAT_C = 4'(MD_LAT);
    localparam bit         MD_EN    = (MD_LAT > 0);

    typedef enum logic [1:0] {EMPTY, FULL, MDWAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        capture;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_u, imm_j;

    logic [3:0]  d_alufn;
    logic [31:0] d_a, d_b;
    logic [4:0]  d_shamt;
    logic        d_wb, d_branch, d_illegal, d_md;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};

    // funct3 -> ALU function for OP / OP-IMM; alt selects SUB / SRA
    function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_map = alt ? FN_SUB : FN_ADD;
            3'b001:  alu_map = FN_SLL;
            3'b010:  alu_map = FN_SLT;
            3'b011:  alu_map = FN_SLTU;
            3'b100:  alu_map = FN_XOR;
            3'b101:  alu_map = alt ? FN_SRA : FN_SRL;
            3'b110:  alu_map = FN_OR;
            default: alu_map = FN_AND;
        endcase
    endfunction

    // Instruction decode into ALU controls
    always_comb begin
        d_alufn   = FN_ADD;
        d_a       = '0;
        d_b       = '0;
        d_shamt   = '0;
        d_wb      = 1'b0;
        d_branch  = 1'b0;
        d_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_a  = in_rs1_val;
                d_b  = in_rs2_val;
                d_wb = 1'b1;
                if (funct7 == 7'b0000001) begin
                    case (funct3)
                        3'b000:  d_alufn = FN_MUL;
                        3'b100:  d_alufn = FN_DIV;
                        3'b110:  d_alufn = FN_REM;
                        default: d_illegal = 1'b1;
                    endcase
                end else if (funct7 == 7'b0000000 ||
                             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    d_alufn = alu_map(funct3, funct7[5]);
                    if (funct3 == 3'b001 || funct3 == 3'b101)
                        d_shamt = in_rs2_val[4:0];
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                d_a  = in_rs1_val;
                d_b  = imm_i;
                d_wb = 1'b1;
                if (funct3 == 3'b001) begin
                    d_alufn   = FN_SLL;
                    d_shamt   = in_instr[24:20];
                    d_illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    d_alufn   = funct7[5] ? FN_SRA : FN_SRL;
                    d_shamt   = in_instr[24:20];
                    d_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end else begin
                    d_alufn = alu_map(funct3, 1'b0);
                end
            end
            OPC_LOAD, OPC_JALR: begin
                d_a  = in_rs1_val;
                d_b  = imm_i;
                d_wb = 1'b1;
            end
            OPC_STORE: begin
                d_a = in_rs1_val;
                d_b = imm_s;
            end
            OPC_BRANCH: begin
                d_alufn  = FN_SUB;
                d_a      = in_rs1_val;
                d_b      = in_rs2_val;
                d_branch = 1'b1;
            end
            OPC_LUI: begin
                d_alufn = FN_PASSB;
                d_b     = imm_u;
                d_wb    = 1'b1;
            end
            OPC_AUIPC: begin
                d_a  = in_pc;
                d_b  = imm_u;
                d_wb = 1'b1;
            end
            OPC_JAL: begin
                d_a  = in_pc;
                d_b  = imm_j;
                d_wb = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_alufn  = FN_ADD;
            d_a      = '0;
            d_b      = '0;
            d_shamt  = '0;
            d_wb     = 1'b0;
            d_branch = 1'b0;
        end
        if (rd == 5'd0)
            d_wb = 1'b0;
    end

    assign d_md      = !d_illegal && (d_alufn == FN_MUL || d_alufn == FN_DIV || d_alufn == FN_REM);
    assign in_ready  = !flush && (state == EMPTY || (state == FULL && out_ready));
    assign out_valid = (state == FULL);
    assign capture   = in_valid && in_ready;

    // State and hold-counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: flush wins, capture reloads, MDWAIT counts down to FULL
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = EMPTY;
            cnt_nxt   = '0;
        end else if (capture) begin
            if (MD_EN && d_md) begin
                state_nxt = MDWAIT;
                cnt_nxt   = MD_LAT_C;
            end else begin
                state_nxt = FULL;
            end
        end else begin
            case (state)
                FULL: begin
                    if (out_ready)
                        state_nxt = EMPTY;
                end
                MDWAIT: begin
                    if (cnt <= 4'd1) begin
                        state_nxt = FULL;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Output register: loads on capture, otherwise holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_a         <= '0;
            out_b         <= '0;
            out_shamt     <= '0;
            out_alufn     <= '0;
            out_rd        <= '0;
            out_wb_en     <= 1'b0;
            out_is_branch <= 1'b0;
            out_funct3    <= '0;
            out_illegal   <= 1'b0;
        end else if (capture) begin
            out_a         <= d_a;
            out_b         <= d_b;
            out_shamt     <= d_shamt;
            out_alufn     <= d_alufn;
            out_rd        <= rd;
            out_wb_en     <= d_wb;
            out_is_branch <= d_branch;
            out_funct3    <= funct3;
            out_illegal   <= d_illegal;
        end
    end

endmodule

// File: tb/tb_prv32_alu_issue.sv
// Directed bench for prv32_alu_issue: decode vector table plus
// hand-written sequences for MD hold, backpressure, flush and reset.
module tb_prv32_alu_issue;

    localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LOAD = 7'b0000011,
                           JALR = 7'b1100111, STORE = 7'b0100011, LUI = 7'b0110111,
                           AUIPC = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val, out_a, out_b;
    logic [4:0]  out_shamt, out_rd;
    logic [3:0]  out_alufn;
    logic        out_wb_en, out_is_branch, out_illegal;
    logic [2:0]  out_funct3;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] instr, pc, rs1, rs2;
        logic [3:0]  alufn;
        logic [31:0] a, b;
        logic [4:0]  shamt, rd;
        logic        wb, br, ill;
        logic [2:0]  f3;
    } vec_t;

    vec_t vecs[$];

    prv32_alu_issue #(.MD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_shamt(out_shamt), .out_alufn(out_alufn),
        .out_rd(out_rd), .out_wb_en(out_wb_en), .out_is_branch(out_is_branch),
        .out_funct3(out_funct3), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], STORE};
    endfunction

    function automatic logic [31:0] b_t(input logic [12:0] off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] j_t(input logic [20:0] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, pc, rs1, rs2,
                                input logic [3:0] alufn, input logic [31:0] a, b,
                                input logic [4:0] shamt, rd,
                                input logic wb, br, ill, input logic [2:0] f3);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.alufn = alufn; v.a = a; v.b = b; v.shamt = shamt; v.rd = rd;
        v.wb = wb; v.br = br; v.ill = ill; v.f3 = f3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, pc, rs1, rs2);
        in_valid   = 1'b1;
        in_instr   = instr;
        in_pc      = pc;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          instr                                pc          rs1           rs2          fn       a             b             sh     rd     wb br il f3
        vecs.push_back(mk(r_t(7'h00,2,1,3'd0,3,OP),       32'h100, 32'd5,        32'd7,       4'b0000, 32'd5,        32'd7,        5'd0,  5'd3,  1,0,0,3'd0));
        vecs.push_back(mk(r_t(7'h20,2,1,3'd0,3,OP),       32'h100, 32'd10,       32'd3,       4'b0001, 32'd10,       32'd3,        5'd0,  5'd3,  1,0,0,3'd0));
        vecs.push_back(mk(i_t(12'h403,4,3'd5,4,OPIMM),    32'h100, 32'h80000000, 32'h55,      4'b1010, 32'h80000000, 32'h403,      5'd3,  5'd4,  1,0,0,3'd5));
        vecs.push_back(mk({20'h12345,5'd5,LUI},           32'h100, 32'hDEAD,     32'h1,       4'b0011, 32'h0,        32'h12345000, 5'd0,  5'd5,  1,0,0,3'd5));
        vecs.push_back(mk(r_t(7'h00,2,1,3'd1,7,OP),       32'h100, 32'd1,        32'h25,      4'b1000, 32'd1,        32'h25,       5'd5,  5'd7,  1,0,0,3'd1));
        vecs.push_back(mk(r_t(7'h00,2,1,3'd2,8,OP),       32'h100, 32'hFFFFFFFD, 32'd2,       4'b1101, 32'hFFFFFFFD, 32'd2,        5'd0,  5'd8,  1,0,0,3'd2));
        vecs.push_back(mk(r_t(7'h00,2,1,3'd3,9,OP),       32'h100, 32'd4,        32'd9,       4'b1111, 32'd4,        32'd9,        5'd0,  5'd9,  1,0,0,3'd3));
        vecs.push_back(mk(r_t(7'h00,2,1,3'd4,10,OP),      32'h100, 32'hF0,       32'h0F,      4'b0111, 32'hF0,       32'h0F,       5'd0,  5'd10, 1,0,0,3'd4));
        vecs.push_back(mk(r_t(7'h00,2,1,3'd5,11,OP),      32'h100, 32'h80,       32'h3F,      4'b1001, 32'h80,       32'h3F,       5'd31, 5'd11, 1,0,0,3'd5));
        vecs.push_back(mk(r_t(7'h00,2,1,3'd6,12,OP),      32'h100, 32'h1,        32'h2,       4'b0100, 32'h1,        32'h2,        5'd0,  5'd12, 1,0,0,3'd6));
        vecs.push_back(mk(r_t(7'h00,2,1,3'd7,13,OP),      32'h100, 32'h3,        32'h6,       4'b0101, 32'h3,        32'h6,        5'd0,  5'd13, 1,0,0,3'd7));
        vecs.push_back(mk(i_t(12'hFFF,0,3'd0,1,OPIMM),    32'h100, 32'h0,        32'h0,       4'b0000, 32'h0,        32'hFFFFFFFF, 5'd0,  5'd1,  1,0,0,3'd0));
        vecs.push_back(mk(i_t(12'h001,0,3'd0,0,OPIMM),    32'h100, 32'h0,        32'h0,       4'b0000, 32'h0,        32'h1,        5'd0,  5'd0,  0,0,0,3'd0));
        vecs.push_back(mk(i_t(12'hFFB,1,3'd2,2,OPIMM),    32'h100, 32'd7,        32'h0,       4'b1101, 32'd7,        32'hFFFFFFFB, 5'd0,  5'd2,  1,0,0,3'd2));
        vecs.push_back(mk(i_t(12'h01F,1,3'd1,1,OPIMM),    32'h100, 32'd3,        32'h0,       4'b1000, 32'd3,        32'h1F,       5'd31, 5'd1,  1,0,0,3'd1));
        vecs.push_back(mk(i_t(12'h41F,1,3'd1,0,OPIMM),    32'h100, 32'd3,        32'h0,       4'b0000, 32'h0,        32'h0,        5'd0,  5'd0,  0,0,1,3'd1));
        vecs.push_back(mk(i_t(12'hFFC,2,3'd2,8,LOAD),     32'h100, 32'h1000,     32'h0,       4'b0000, 32'h1000,     32'hFFFFFFFC, 5'd0,  5'd8,  1,0,0,3'd2));
        vecs.push_back(mk(s_t(12'd32,3,2,3'd2),           32'h100, 32'h2000,     32'h77,      4'b0000, 32'h2000,     32'd32,       5'd0,  5'd0,  0,0,0,3'd2));
        vecs.push_back(mk(b_t(13'd32,2,1,3'd4),           32'h100, 32'hFFFFFFFF, 32'd1,       4'b0001, 32'hFFFFFFFF, 32'd1,        5'd0,  5'd0,  0,1,0,3'd4));
        vecs.push_back(mk({20'h00001,5'd9,AUIPC},         32'h100, 32'h5,        32'h0,       4'b0000, 32'h100,      32'h1000,     5'd0,  5'd9,  1,0,0,3'd1));
        vecs.push_back(mk(j_t(21'h1FFFF8,1),              32'h200, 32'h5,        32'h0,       4'b0000, 32'h200,      32'hFFFFFFF8, 5'd0,  5'd1,  1,0,0,3'd7));
        vecs.push_back(mk(i_t(12'h004,5,3'd0,1,JALR),     32'h100, 32'h3000,     32'h0,       4'b0000, 32'h3000,     32'h4,        5'd0,  5'd1,  1,0,0,3'd0));
        vecs.push_back(mk(32'h0000007F,                   32'h100, 32'd5,        32'd6,       4'b0000, 32'h0,        32'h0,        5'd0,  5'd0,  0,0,1,3'd0));
        vecs.push_back(mk(r_t(7'h01,2,1,3'd1,0,OP),       32'h100, 32'd5,        32'd6,       4'b0000, 32'h0,        32'h0,        5'd0,  5'd0,  0,0,1,3'd1));

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
        step(); step();
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset alufn", out_alufn, 0);
        chk("reset a", out_a, 0);
        chk("reset b", out_b, 0);
        chk("reset wb_en", out_wb_en, 0);
        rst_n = 1'b1;
        step();

        // back-to-back decode table, out_ready tied high
        foreach (vecs[i]) begin
            chk($sformatf("v%0d in_ready", i), in_ready, 1);
            drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            step();
            chk($sformatf("v%0d out_valid", i), out_valid, 1);
            chk($sformatf("v%0d alufn", i), out_alufn, vecs[i].alufn);
            chk($sformatf("v%0d a", i), out_a, vecs[i].a);
            chk($sformatf("v%0d b", i), out_b, vecs[i].b);
            chk($sformatf("v%0d shamt", i), out_shamt, vecs[i].shamt);
            chk($sformatf("v%0d rd", i), out_rd, vecs[i].rd);
            chk($sformatf("v%0d wb_en", i), out_wb_en, vecs[i].wb);
            chk($sformatf("v%0d is_branch", i), out_is_branch, vecs[i].br);
            chk($sformatf("v%0d illegal", i), out_illegal, vecs[i].ill);
            chk($sformatf("v%0d funct3", i), out_funct3, vecs[i].f3);
        end
        in_valid = 1'b0;
        step();
        chk("table drain out_valid", out_valid, 0);

        // mul held two extra cycles
        drive(r_t(7'h01,2,1,3'd0,6,OP), 32'h100, 32'd3, 32'd4);
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("mul hold%0d out_valid", c), out_valid, 0);
            chk($sformatf("mul hold%0d in_ready", c), in_ready, 0);
            chk($sformatf("mul hold%0d a", c), out_a, 3);
            chk($sformatf("mul hold%0d b", c), out_b, 4);
            step();
        end
        chk("mul out_valid", out_valid, 1);
        chk("mul alufn", out_alufn, 4'b1011);
        chk("mul a", out_a, 3);
        chk("mul b", out_b, 4);
        chk("mul rd", out_rd, 6);
        step();
        chk("mul drain out_valid", out_valid, 0);

        // beq under backpressure; a competing add must not be captured
        out_ready = 1'b0;
        drive(b_t(13'd32,2,1,3'd0), 32'h100, 32'd9, 32'd9);
        step();
        drive(r_t(7'h00,2,1,3'd0,3,OP), 32'h100, 32'd1, 32'd2);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("beq stall%0d out_valid", c), out_valid, 1);
            chk($sformatf("beq stall%0d in_ready", c), in_ready, 0);
            chk($sformatf("beq stall%0d alufn", c), out_alufn, 4'b0001);
            chk($sformatf("beq stall%0d is_branch", c), out_is_branch, 1);
            chk($sformatf("beq stall%0d wb_en", c), out_wb_en, 0);
            chk($sformatf("beq stall%0d a", c), out_a, 9);
            chk($sformatf("beq stall%0d b", c), out_b, 9);
            if (c < 2) step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("beq drain out_valid", out_valid, 0);

        // flush during MDWAIT for div
        drive(r_t(7'h01,2,1,3'd4,7,OP), 32'h100, 32'd20, 32'd4);
        step();
        in_valid = 1'b0;
        chk("div mdwait out_valid", out_valid, 0);
        flush = 1'b1;
        #1;
        chk("flush in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        #1;
        chk("post-flush out_valid", out_valid, 0);
        chk("post-flush in_ready", in_ready, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("post-flush idle%0d out_valid", c), out_valid, 0);
        end
        drive(i_t(12'hFFF,0,3'd0,1,OPIMM), 32'h100, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("addi after flush out_valid", out_valid, 1);
        chk("addi after flush b", out_b, 32'hFFFFFFFF);
        chk("addi after flush alufn", out_alufn, 0);
        step();

        // reset while FULL loses the op
        out_ready = 1'b0;
        drive(r_t(7'h00,2,1,3'd0,3,OP), 32'h100, 32'd5, 32'd7);
        step();
        in_valid = 1'b0;
        chk("pre-reset out_valid", out_valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("reset-in-full out_valid", out_valid, 0);
        chk("reset-in-full a", out_a, 0);
        chk("reset-in-full wb_en", out_wb_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prv32_alu_issue.md
Name: prv32_alu_issue

Overview:
- ID/EX issue stage that drives the prv32 ALU: decodes an RV32I/M instruction into the ALU operation code, operands and shift amount, and registers them toward EX.
- Sits between decode/register-file read and the ALU; it is the encoding end of the ALU's `alufn` interface.
- Valid/ready handshake on both sides, synchronous flush.
- MUL/DIV/REM are held for a programmable number of extra cycles so the combinational ALU multiply/divide path can settle before EX samples.

Parameters:
- MD_LAT, 2, extra cycles `out_*` are held stable (`out_valid` low) for MUL/DIV/REM; 0 = no extra hold; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- flush  input  1  discard held or waiting op; block capture this cycle
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  block accepts this cycle
- in_instr  input  32  instruction word
- in_pc  input  32  instruction PC
- in_rs1_val  input  32  rs1 register value
- in_rs2_val  input  32  rs2 register value
- out_valid  output  1  registered op valid toward EX
- out_ready  input  1  EX consumes op
- out_a  output  32  ALU operand a
- out_b  output  32  ALU operand b
- out_shamt  output  5  ALU shift amount
- out_alufn  output  4  ALU function code
- out_rd  output  5  destination register
- out_wb_en  output  1  op writes rd (forced 0 when rd==0)
- out_is_branch  output  1  conditional branch (ALU flags used)
- out_funct3  output  3  `in_instr[14:12]` passthrough
- out_illegal  output  1  unsupported encoding

Behaviour:
- Reset (`rst_n` = 0 at a rising edge): state EMPTY, all outputs 0, counter 0.
- States:
  - EMPTY, FULL, MDWAIT.
  - `in_ready` = !flush && (EMPTY || (FULL && out_ready)).
  - `out_valid` = (state == FULL).
- Capture on `in_valid && in_ready`: all `out_*` registered at that edge.
  - Next state is FULL, or MDWAIT if the op decodes to MUL/DIV/REM and MD_LAT > 0.
  - In MDWAIT the counter loads MD_LAT and decrements each edge; when it reaches 1 the next edge enters FULL.
  - `out_valid` therefore rises MD_LAT edges later than for non-MD ops.
  - `out_*` are stable throughout MDWAIT.
- FULL with `out_ready`:
  - With a capture in the same cycle: reload, giving 1 op/cycle throughput for non-MD ops.
  - Otherwise: go to EMPTY.
- FULL without `out_ready`: hold all outputs unchanged.
- flush: highest priority after reset. Next state EMPTY, `out_valid` 0, counter cleared, no capture. Data outputs may keep stale values.
- `alufn` encoding (fixed):
  - ADD 0000, SUB 0001, REM 0010, PASSB 0011
  - OR 0100, AND 0101, XOR 0111
  - SLL 1000, SRL 1001, SRA 1010, MUL 1011
  - SLT 1101, DIV 1110, SLTU 1111
- Decode by opcode:
  - OP (0110011), `funct7` 0000000/0100000, `funct3` mapping:
    - 000 ADD/SUB (SUB when `funct7[5]`)
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
    - 101 SRL/SRA (SRA when `funct7[5]`)
    - 110 OR, 111 AND
    - a = rs1, b = rs2, shamt = `rs2[4:0]`.
  - OP with `funct7` 0000001: `funct3` 000 MUL, 100 DIV, 110 REM; all other `funct3` values are illegal.
  - OP-IMM (0010011):
    - same mapping, no SUB.
    - b = sign-extended I-immediate, shamt = `instr[24:20]`.
    - Shift `funct7` must be 0000000, or 0100000 for SRAI; otherwise illegal.
  - LOAD (0000011) and JALR (1100111): ADD, a = rs1, b = I-immediate.
  - STORE (0100011): ADD, a = rs1, b = S-immediate, `wb_en` 0.
  - BRANCH (1100011): SUB, a = rs1, b = rs2, `is_branch` 1, `wb_en` 0.
  - LUI (0110111): PASSB, a = 0, b = `{instr[31:12], 12'b0}`.
  - AUIPC (0010111): ADD, a = pc, b = U-immediate.
  - JAL (1101111): ADD, a = pc, b = sign-extended J-immediate.
- Illegal (any other opcode or `funct` combination): `out_illegal` 1, `alufn` ADD, a = b = 0, shamt 0, `wb_en` 0. It is still issued normally (no MD hold).
- shamt is 0 for non-shift ops.
- Reset asserted during MDWAIT or FULL: EMPTY on that edge, the op is lost.

Test Plan:
- Reset, then `add x3,x1,x2` with rs1 = 5, rs2 = 7, `out_ready` = 1 -> `out_valid` 1 the next cycle; alufn 0000, a = 5, b = 7, rd = 3, `wb_en` 1.
- Back-to-back `sub`, `srai x4,x4,3` (rs1 = 0x80000000), `lui x5,0x12345` with `out_ready` tied 1 -> three consecutive valid cycles:
  - 0001
  - 1010 with shamt = 3
  - 0011 with a = 0, b = 0x12345000
- `mul x6,x1,x2` with MD_LAT = 2 -> `in_ready` 0 and `out_valid` 0 for 2 cycles after capture; alufn 1011 on the third cycle with a/b unchanged throughout.
- `beq` with rs1 = rs2 = 9 and `out_ready` held 0 for 3 cycles -> `out_valid` held, outputs frozen, `in_ready` 0; alufn 0001, `is_branch` 1, `wb_en` 0; drains when `out_ready` = 1.
- flush asserted during MDWAIT for `div` -> `out_valid` never rises, state EMPTY the next cycle, a new `addi x1,x0,-1` issues with b = 0xFFFFFFFF.
- Opcode 0x7F, and `mulh` (OP, `funct7` 0000001, `funct3` 001) -> `out_illegal` 1, a = b = 0, `wb_en` 0, no MD hold; `addi x0,x0,1` -> `wb_en` 0.
